arm_fetch_unit: RTL and testbench
=================================

# arm_fetch_unit

Instruction fetch stage between instruction memory and the ARM core's decode/execute path. Holds the fetch PC, issues one-outstanding-request reads to instruction memory over a req/ack handshake, and buffers returned words with their PCs in a small prefetch FIFO. The FIFO drains to the core over a valid/ready handshake. A core redirect (branch or PC write) flushes all buffered and in-flight instructions and restarts fetch at the new PC.

## Interface
- DEPTH, 4, prefetch FIFO entries; power of two, minimum 2
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  reset, synchronous, active-low (rst==0 resets)
- imem_req  output  1  read request to instruction memory
- imem_addr  output  32  word address of the request; always 4-byte aligned
- imem_ack  input  1  memory completes the request this cycle; may coincide with the first cycle of imem_req
- imem_rdata  input  32  instruction word; sampled only when imem_req && imem_ack
- inst_valid  output  1  FIFO head is valid
- inst  output  32  FIFO head instruction word
- inst_pc  output  32  address that inst was fetched from
- inst_ready  input  1  core consumes the head when inst_valid && inst_ready
- redirect_valid  input  1  core PC write; flush and refetch
- redirect_pc  input  32  new fetch address; bits [1:0] ignored (forced to 0)
- fetch_halted  output  1  halt word fetched; see Configuration

## Operation
- State: fetch_pc (32), FIFO of {pc, word} x DEPTH, count (clog2(DEPTH)+1 bits), outstanding flag, discard flag.
- Issue rule: imem_req=1 when (count + outstanding) < DEPTH and not halted, or whenever a request is already outstanding. imem_addr = fetch_pc.
- Once imem_req rises it stays high with imem_addr stable until imem_ack; requests are never withdrawn.
- On imem_req && imem_ack with discard==0: push {fetch_pc, imem_rdata}; fetch_pc <= fetch_pc + 4 (wraps mod 2^32).
- On ack with discard==1: word dropped, discard cleared, no push, fetch_pc unchanged.
- Pop on inst_valid && inst_ready; head advances. Push and pop may occur in the same cycle; count unchanged.
- Redirect (highest priority): FIFO emptied (count<=0, pointers reset), fetch_pc <= {redirect_pc[31:2],2'b00}, pop that cycle ignored. If a request is in flight and not acked in the redirect cycle, discard<=1. If ack coincides with redirect, the word is dropped, no discard flag set.
- After a redirect with discard pending, the next request at the new PC issues the cycle after the stale ack.
- Credit accounting guarantees no push into a full FIFO; overflow is impossible by construction.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, fetch_halted=0, count=0, discard=0, outstanding=0.
- First cycle with rst==1: imem_req=1, imem_addr=RESET_PC.
- Fetch-to-valid latency: word acked in cycle N appears with inst_valid=1 in cycle N+1.
- Zero-wait memory (ack every cycle) sustains one instruction per cycle when the core pops every cycle.
- Redirect in cycle N: inst_valid=0 in cycle N+1; imem_addr=redirect_pc in N+1 (if no stale request pending).
- rst==0 mid-request: all state cleared; memory must tolerate request withdrawal at reset only.

## Configuration
- FETCH_HALT_EN defined: when a pushed word equals 32'he3a000bb, fetch_halted<=1 next cycle and no further requests issue (buffered words still drain). A redirect clears fetch_halted and resumes fetch.
- Undefined: fetch_halted tied 0; fetch never stops.

## Test plan
- Reset release, ack same-cycle, inst_ready=1: imem_addr 0,4,8,... on consecutive cycles; inst_pc 0,4,8 one cycle later, one per cycle.
- inst_ready=0, zero-wait memory, DEPTH=4: exactly 4 acks, imem_req drops, count=4; raise inst_ready -> requests resume at 0x10.
- Memory ack delay 3 cycles, redirect to 0x100 in the middle cycle: req stays high at old address until ack, word dropped, next req at 0x100, inst_pc first valid = 0x100.
- Redirect to 0x203 coincident with ack and pop: FIFO empty next cycle, next imem_addr=0x200, acked word not delivered.
- FETCH_HALT_EN, word at 0x8 = e3a000bb: fetch_halted=1, no request for 0xC, instructions 0x0..0x8 drain; redirect to 0x40 clears halt and fetches 0x40.
- rst=0 asserted while 2 entries buffered and a request outstanding: next cycle all outputs at reset values.

Source files
------------

// File: rtl/arm_fetch_if.sv
// arm_fetch_if: fetch-unit bus bundle; master = fetch unit, slave = memory/core side
interface arm_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_halted;
  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_halted,
    input  imem_ack, imem_rdata, inst_ready, redirect_valid, redirect_pc
  );
  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_halted,
    output imem_ack, imem_rdata, inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/arm_fetch_unit.sv
// arm_fetch_unit: one-outstanding imem fetch into a prefetch FIFO, drained by the core, flushed on redirect
// Ports: clk; rst (synchronous, active-low); io_bus (arm_fetch_if.master): imem req/addr/ack/rdata,
//   inst valid/ready/inst/inst_pc, redirect valid/pc, fetch_halted.
// Build option: FETCH_HALT_EN stops issuing requests once the halt word 32'he3a000bb is buffered.
module arm_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  arm_fetch_if.master io_bus
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] r_pc, r_addr;
  logic [31:0] r_mem_pc [DEPTH];
  logic [31:0] r_mem_w [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_count;
  logic r_out, r_discard;
  logic w_halt, w_req, w_ack, w_push, w_pop, w_valid, w_unused;
  logic [AW+1:0] w_used;
  // credits: buffered entries plus the in-flight word must fit the FIFO
  assign w_used = {1'b0, r_count} + (AW+2)'(r_out);
  assign w_req = rst && (r_out || (w_used < (AW+2)'(DEPTH) && !w_halt));
  assign w_ack = w_req && io_bus.imem_ack;
  assign w_push = w_ack && !r_discard && !io_bus.redirect_valid;
  assign w_valid = r_count != '0;
  assign w_pop = w_valid && io_bus.inst_ready && !io_bus.redirect_valid;
  assign w_unused = ^io_bus.redirect_pc[1:0];
  assign io_bus.imem_req = w_req;
  // an in-flight request keeps its original address even after a redirect moved r_pc
  assign io_bus.imem_addr = r_out ? r_addr : r_pc;
  assign io_bus.inst_valid = w_valid;
  assign io_bus.inst = w_valid ? r_mem_w[r_rd] : '0;
  assign io_bus.inst_pc = w_valid ? r_mem_pc[r_rd] : '0;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc <= {RESET_PC[31:2], 2'b00};
      r_addr <= {RESET_PC[31:2], 2'b00};
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
      r_out <= 1'b0;
      r_discard <= 1'b0;
    end else begin
      r_addr <= io_bus.imem_addr;
      r_out <= w_req && !io_bus.imem_ack;
      if (io_bus.redirect_valid) begin
        r_pc <= {io_bus.redirect_pc[31:2], 2'b00};
        r_wr <= '0;
        r_rd <= '0;
        r_count <= '0;
        r_discard <= w_req && !io_bus.imem_ack;
      end else begin
        if (w_ack) r_discard <= 1'b0;
        if (w_push) r_pc <= r_pc + 32'd4;
        if (w_push) r_wr <= r_wr + AW'(1);
        if (w_pop) r_rd <= r_rd + AW'(1);
        r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr] <= r_pc;
      r_mem_w[r_wr] <= io_bus.imem_rdata;
    end
  end
`ifdef FETCH_HALT_EN
  logic r_halt;
  always_ff @(posedge clk) begin
    if (!rst) r_halt <= 1'b0;
    else if (io_bus.redirect_valid) r_halt <= 1'b0;
    else if (w_push && io_bus.imem_rdata == 32'he3a000bb) r_halt <= 1'b1;
  end
  assign w_halt = r_halt;
`else
  assign w_halt = 1'b0;
`endif
  assign io_bus.fetch_halted = w_halt;
endmodule

// File: tb/tb_arm_fetch_unit.sv
// tb_arm_fetch_unit: directed stimulus with a scoreboard of expected {pc, word} deliveries
module tb_arm_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  arm_fetch_if bus();
  arm_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .io_bus(bus));
  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] halt_addr = 32'hffff_ffff;
  function automatic logic [31:0] word(input logic [31:0] a);
    return a == halt_addr ? 32'he3a000bb : {~a[15:0], a[15:0]};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  task automatic step(input logic ack, input logic ready, input logic redir,
                      input logic [31:0] rpc, input logic keep);
    logic [63:0] e;
    @(negedge clk);
    bus.imem_ack = ack;
    bus.inst_ready = ready;
    bus.redirect_valid = redir;
    bus.redirect_pc = rpc;
    bus.imem_rdata = word(bus.imem_addr);
    #1;
    if (keep) begin
      chk("fetch_req", {31'b0, bus.imem_req}, 32'd1);
      chk("fetch_addr", bus.imem_addr, exp_pc);
      sb.push_back({exp_pc, word(exp_pc)});
      exp_pc += 32'd4;
    end
    if (redir) sb.delete();
    else if (bus.inst_valid && ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_pop observed=%h expected=none", bus.inst_pc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("inst_pc", bus.inst_pc, e[63:32]);
        chk("inst", bus.inst, e[31:0]);
      end
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.imem_ack = 1'b0;
    bus.inst_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_valid", {31'b0, bus.inst_valid}, 32'd0);
    chk("rst_inst", bus.inst, 32'h0);
    chk("rst_inst_pc", bus.inst_pc, 32'h0);
    chk("rst_halted", {31'b0, bus.fetch_halted}, 32'd0);
    sb.delete();
    exp_pc = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("first_req", {31'b0, bus.imem_req}, 32'd1);
    chk("first_addr", bus.imem_addr, 32'h0);
  endtask
  initial begin
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.inst_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("stream_sb_empty", sb.size(), 32'd0);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("full_req", {31'b0, bus.imem_req}, 32'd0);
    chk("full_valid", {31'b0, bus.inst_valid}, 32'd1);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("full_req_pop", {31'b0, bus.imem_req}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("drain_valid", {31'b0, bus.inst_valid}, 32'd0);
    chk("full_sb_empty", sb.size(), 32'd0);
    do_reset();
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("wait_addr", bus.imem_addr, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h100, 1'b0);
    chk("redir_req", {31'b0, bus.imem_req}, 32'd1);
    chk("redir_addr", bus.imem_addr, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("stale_req", {31'b0, bus.imem_req}, 32'd1);
    chk("stale_addr", bus.imem_addr, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("new_req", {31'b0, bus.imem_req}, 32'd1);
    chk("new_addr", bus.imem_addr, 32'h100);
    chk("dropped_valid", {31'b0, bus.inst_valid}, 32'd0);
    exp_pc = 32'h100;
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("delay_sb_empty", sb.size(), 32'd0);
    do_reset();
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 32'h203, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("coinc_valid", {31'b0, bus.inst_valid}, 32'd0);
    chk("coinc_req", {31'b0, bus.imem_req}, 32'd1);
    chk("coinc_addr", bus.imem_addr, 32'h200);
    exp_pc = 32'h200;
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("coinc_sb_empty", sb.size(), 32'd0);
`ifdef FETCH_HALT_EN
    do_reset();
    halt_addr = 32'h8;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("halt_set", {31'b0, bus.fetch_halted}, 32'd1);
    chk("halt_req", {31'b0, bus.imem_req}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("halt_req_hold", {31'b0, bus.imem_req}, 32'd0);
    chk("halt_drained", {31'b0, bus.inst_valid}, 32'd0);
    step(1'b0, 1'b1, 1'b1, 32'h40, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("halt_clear", {31'b0, bus.fetch_halted}, 32'd0);
    chk("halt_resume_addr", bus.imem_addr, 32'h40);
    halt_addr = 32'hffff_ffff;
    exp_pc = 32'h40;
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("halt_sb_empty", sb.size(), 32'd0);
`endif
    do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("mid_valid", {31'b0, bus.inst_valid}, 32'd1);
    chk("mid_req", {31'b0, bus.imem_req}, 32'd1);
    do_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
